// File: rtl/pixel_array_ctrl.sv
// pixel_array_ctrl: Wishbone-programmed sequencer driving per-channel
// pixel switches through reset, local and adjacent integration phases.
module pixel_array_ctrl #(
  parameter int         NCH      = 4,
  parameter int         TW       = 10,
  parameter logic [3:0] BASE_NIB = 4'h3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wbs_cyc_i,
  input  logic           wbs_stb_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  input  logic           ext_start_i,
  output logic [NCH-1:0] s_rst_o,
  output logic [NCH-1:0] s_p1_o,
  output logic [NCH-1:0] s_p2_o,
  output logic [NCH-1:0] pxl_done_o,
  output logic           all_done_o,
  output logic           irq_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOC, S_ADJ, S_DONE
  } st_t;

  logic           r_ack;
  logic [31:0]    r_dat;
  logic           r_ext_q;
  logic [NCH-1:0] r_en;
  logic [NCH-1:0] r_done;
  logic [NCH-1:0] r_irq_en;
  logic [TW-1:0]  r_loc [NCH];
  logic [TW-1:0]  r_adj [NCH];
  logic           r_irq;
  logic           r_alld;

  logic           w_hit;
  logic           w_acc;
  logic           w_wr;
  logic [5:0]     w_off;
  logic [31:0]    w_bm;
  logic [31:0]    w_wd;
  logic           w_wr_ctrl;
  logic           w_abort;
  logic           w_start;
  logic [NCH-1:0] w_en_nxt;
  logic [NCH-1:0] w_irqen_nxt;
  logic [NCH-1:0] w_w1c;
  logic [NCH-1:0] w_done_nxt;
  logic [NCH-1:0] w_busy;
  logic [NCH-1:0] w_dset;
  logic [31:0]    w_rd;
  logic           w_unused;

  // The cycle carrying an ack is never a new access.
  assign w_hit = wbs_cyc_i & wbs_stb_i
               & (wbs_adr_i[31:28] == BASE_NIB);
  assign w_acc = w_hit & ~r_ack;
  assign w_wr  = w_acc & wbs_we_i;
  assign w_off = wbs_adr_i[7:2];
  assign w_bm  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign w_wd  = wbs_dat_i & w_bm;

  assign w_wr_ctrl = w_wr & (w_off == 6'd0);
  assign w_abort   = w_wr_ctrl & w_wd[1];
  assign w_start   = ((w_wr_ctrl & w_wd[0])
                   | (ext_start_i & ~r_ext_q)) & ~w_abort;

  assign w_en_nxt = w_wr_ctrl
    ? ((r_en & ~w_bm[8 +: NCH]) | w_wd[8 +: NCH]) : r_en;
  assign w_irqen_nxt = (w_wr && w_off == 6'd2)
    ? ((r_irq_en & ~w_bm[NCH-1:0]) | w_wd[NCH-1:0]) : r_irq_en;
  assign w_w1c = (w_wr && w_off == 6'd1) ? w_wd[8 +: NCH] : '0;
  assign w_done_nxt = (r_done & ~w_w1c) | w_dset;

  assign w_unused = ^{wbs_adr_i[27:8], wbs_adr_i[1:0], w_bm, w_wd};

  always_comb begin
    w_rd = '0;
    case (w_off)
      6'd0: w_rd[8 +: NCH] = r_en;
      6'd1: begin
        w_rd[NCH-1:0]  = w_busy;
        w_rd[8 +: NCH] = r_done;
      end
      6'd2: w_rd[NCH-1:0] = r_irq_en;
      default: begin
        for (int c = 0; c < NCH; c++) begin
          if (w_off == 6'(16 + 2*c)) w_rd[TW-1:0] = r_loc[c];
          if (w_off == 6'(17 + 2*c)) w_rd[TW-1:0] = r_adj[c];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_ext_q  <= 1'b0;
      r_en     <= '0;
      r_done   <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
      r_alld   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_loc[c] <= '0;
        r_adj[c] <= '0;
      end
    end else begin
      r_ack    <= w_acc;
      r_dat    <= (w_acc & ~wbs_we_i) ? w_rd : '0;
      r_ext_q  <= ext_start_i;
      r_en     <= w_en_nxt;
      r_done   <= w_done_nxt;
      r_irq_en <= w_irqen_nxt;
      r_irq    <= |(w_done_nxt & w_irqen_nxt);
      r_alld   <= (w_en_nxt != '0)
               && ((w_done_nxt & w_en_nxt) == w_en_nxt);
      for (int c = 0; c < NCH; c++) begin
        if (w_wr && w_off == 6'(16 + 2*c))
          r_loc[c] <= (r_loc[c] & ~w_bm[TW-1:0]) | w_wd[TW-1:0];
        if (w_wr && w_off == 6'(17 + 2*c))
          r_adj[c] <= (r_adj[c] & ~w_bm[TW-1:0]) | w_wd[TW-1:0];
      end
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign irq_o      = r_irq;
  assign all_done_o = r_alld;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    st_t           r_st;
    st_t           w_st;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt;
    logic [TW-1:0] r_lmax;
    logic [TW-1:0] w_lmax;
    logic [TW-1:0] r_amax;
    logic [TW-1:0] w_amax;
    logic          r_srst;
    logic          r_sp1;
    logic          r_sp2;
    logic          r_pd;

    always_comb begin
      w_st   = r_st;
      w_cnt  = r_cnt + TW'(1);
      w_lmax = r_lmax;
      w_amax = r_amax;
      unique case (r_st)
        S_IDLE: begin
          w_cnt = '0;
          if (w_start && w_en_nxt[g]) begin
            w_st   = S_RST;
            w_lmax = r_loc[g];
            w_amax = r_adj[g];
          end
        end
        S_RST: begin
          w_st  = S_LOC;
          w_cnt = '0;
        end
        S_LOC: begin
          if (r_cnt == r_lmax) begin
            w_st  = S_ADJ;
            w_cnt = '0;
          end
        end
        S_ADJ: begin
          if (r_cnt == r_amax) begin
            w_st  = S_DONE;
            w_cnt = '0;
          end
        end
        S_DONE: begin
          w_st  = S_IDLE;
          w_cnt = '0;
        end
        default: begin
          w_st  = S_IDLE;
          w_cnt = '0;
        end
      endcase
      if (w_abort) begin
        w_st  = S_IDLE;
        w_cnt = '0;
      end
    end

    // Switch outputs are registered from the next state.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_st   <= S_IDLE;
        r_cnt  <= '0;
        r_lmax <= '0;
        r_amax <= '0;
        r_srst <= 1'b0;
        r_sp1  <= 1'b0;
        r_sp2  <= 1'b0;
        r_pd   <= 1'b0;
      end else begin
        r_st   <= w_st;
        r_cnt  <= w_cnt;
        r_lmax <= w_lmax;
        r_amax <= w_amax;
        r_srst <= (w_st == S_RST);
        r_sp1  <= (w_st == S_LOC);
        r_sp2  <= (w_st == S_ADJ);
        r_pd   <= (w_st == S_DONE);
      end
    end

    assign s_rst_o[g]    = r_srst;
    assign s_p1_o[g]     = r_sp1;
    assign s_p2_o[g]     = r_sp2;
    assign pxl_done_o[g] = r_pd;
    assign w_busy[g]     = (r_st != S_IDLE);
    assign w_dset[g]     = (r_st == S_DONE);
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: register access, channel
// sequencing, abort, interrupts, external start and reset behaviour.
module tb_pixel_array_ctrl;

  localparam int NCH = 4;
  localparam logic [31:0] A_CTRL = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_IRQE = 32'h3000_0008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0;
  logic stb = 1'b0;
  logic we = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic ack;
  logic [31:0] rdat;
  logic ext = 1'b0;
  logic [NCH-1:0] srst, sp1, sp2, pdone;
  logic alld, irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [NCH-1:0] h_r [64];
  logic [NCH-1:0] h_1 [64];
  logic [NCH-1:0] h_2 [64];
  logic [NCH-1:0] h_d [64];

  always #5 clk = ~clk;

  pixel_array_ctrl dut (
    .clk(clk), .rst(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .ext_start_i(ext),
    .s_rst_o(srst), .s_p1_o(sp1), .s_p2_o(sp2),
    .pxl_done_o(pdone), .all_done_o(alld), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("wr_ack", 32'(got), 1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d,
                         output logic got);
    got = 1'b0;
    d = '0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        d = rdat;
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic mon(input int n);
    for (int i = 0; i < n; i++) begin
      h_r[i] = srst; h_1[i] = sp1; h_2[i] = sp2; h_d[i] = pdone;
      @(posedge clk); #1;
    end
  endtask

  task automatic tally(input int n, input int c, output int nr,
                       output int n1, output int n2, output int nd,
                       output int fd, output int oh);
    nr = 0; n1 = 0; n2 = 0; nd = 0; fd = -1; oh = 0;
    for (int i = 0; i < n; i++) begin
      nr += int'(h_r[i][c]);
      n1 += int'(h_1[i][c]);
      n2 += int'(h_2[i][c]);
      nd += int'(h_d[i][c]);
      if (h_d[i][c] && fd < 0) fd = i;
      if (int'(h_r[i][c]) + int'(h_1[i][c]) + int'(h_2[i][c]) > 1)
        oh++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic got;
    logic [3:0] pat;
    int nr, n1, n2, nd, fd, oh;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw", 32'({srst, sp1, sp2, pdone}), 0);
    chk("rst_misc", 32'({alld, irq, ack}), 0);
    chk("rst_dat", rdat, 0);
    rst = 1'b0;

    wb_read(A_STAT, d, got);
    chk("stat0_ack", 32'(got), 1);
    chk("stat0", d, 0);

    wb_write(A_CTRL, 32'h0000_0F00, 4'h1);
    wb_read(A_CTRL, d, got);
    chk("en_lane0_only", d, 0);
    wb_write(A_CTRL, 32'h0000_0F00, 4'h2);
    wb_read(A_CTRL, d, got);
    chk("en_lane1", d, 32'h0000_0F00);

    wb_write(32'h3000_0040, 32'd3, 4'hF);
    wb_write(32'h3000_0044, 32'd2, 4'hF);
    wb_write(32'h3000_0050, 32'hFFFF_FFFF, 4'h1);
    wb_read(32'h3000_0050, d, got);
    chk("loc2_lane0", d, 32'h0000_00FF);
    wb_write(32'h3000_0050, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h3000_0050, d, got);
    chk("loc2_width", d, 32'h0000_03FF);
    wb_write(32'h3000_0050, 32'd0, 4'hF);
    wb_read(32'h3000_0040, d, got);
    chk("loc0_rd", d, 3);
    wb_read(32'h3000_0044, d, got);
    chk("adj0_rd", d, 2);

    wb_write(A_CTRL, 32'h0000_0F01, 4'hF);
    mon(12);
    tally(12, 0, nr, n1, n2, nd, fd, oh);
    chk("ch0_rst_cyc", nr, 1);
    chk("ch0_p1_cyc", n1, 4);
    chk("ch0_p2_cyc", n2, 3);
    chk("ch0_done_cnt", nd, 1);
    chk("ch0_done_at9", fd, 8);
    chk("ch0_onehot", oh, 0);
    tally(12, 1, nr, n1, n2, nd, fd, oh);
    chk("ch1_p1_max0", n1, 1);
    chk("ch1_p2_max0", n2, 1);
    chk("ch1_done_at4", fd, 3);
    wb_read(A_STAT, d, got);
    chk("stat_done_all", d, 32'h0000_0F00);
    wb_read(A_CTRL, d, got);
    chk("ctrl_start_rd0", d, 32'h0000_0F00);
    chk("all_done", 32'(alld), 1);
    chk("irq_off", 32'(irq), 0);

    wb_write(A_IRQE, 32'h0000_0002, 4'hF);
    chk("irq_on", 32'(irq), 1);
    wb_write(A_STAT, 32'h0000_0200, 4'hF);
    chk("irq_w1c", 32'(irq), 0);
    chk("all_done_w1c", 32'(alld), 0);
    wb_read(A_STAT, d, got);
    chk("stat_w1c", d, 32'h0000_0D00);

    wb_write(A_STAT, 32'h0000_0F00, 4'hF);
    wb_write(A_CTRL, 32'h0000_0F01, 4'hF);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pd_cycle4", 32'(pdone), 32'h0000_000E);
    wb_write(A_STAT, 32'h0000_0200, 4'hF);
    wb_read(A_STAT, d, got);
    chk("set_beats_w1c", d, 32'h0000_0E01);
    chk("irq_set_wins", 32'(irq), 1);
    repeat (8) begin
      @(posedge clk); #1;
    end
    wb_read(A_STAT, d, got);
    chk("stat_ch0_fin", d, 32'h0000_0F00);

    wb_write(A_CTRL, 32'h0000_0100, 4'hF);
    wb_write(A_CTRL, 32'h0000_0101, 4'hF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_p1", 32'(sp1), 1);
    wb_write(A_CTRL, 32'h0000_0102, 4'hF);
    chk("abort_sw0", 32'({srst, sp1, sp2, pdone}), 0);
    mon(12);
    tally(12, 0, nr, n1, n2, nd, fd, oh);
    chk("abort_quiet", nr + n1 + n2 + nd, 0);
    wb_read(A_STAT, d, got);
    chk("abort_stat", d, 32'h0000_0F00);
    wb_write(A_CTRL, 32'h0000_0103, 4'hF);
    chk("abst_no_rst", 32'(srst), 0);
    mon(10);
    tally(10, 0, nr, n1, n2, nd, fd, oh);
    chk("abst_no_run", nr + n1 + n2 + nd, 0);

    wb_write(A_STAT, 32'h0000_0F00, 4'hF);
    ext = 1'b1;
    mon(20);
    tally(20, 0, nr, n1, n2, nd, fd, oh);
    chk("ext_rst_once", nr, 1);
    chk("ext_done_once", nd, 1);
    chk("ext_done_at", fd, 9);
    ext = 1'b0;
    mon(10);
    tally(10, 0, nr, n1, n2, nd, fd, oh);
    chk("ext_no_rerun", nr + nd, 0);
    wb_read(A_STAT, d, got);
    chk("ext_stat", d, 32'h0000_0100);
    chk("ext_all_done", 32'(alld), 1);

    wb_write(A_CTRL, 32'h0000_0101, 4'hF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    wb_write(A_CTRL, 32'h0000_0101, 4'hF);
    mon(20);
    tally(20, 0, nr, n1, n2, nd, fd, oh);
    chk("busy_start_ign", nr, 0);
    chk("busy_one_done", nd, 1);

    wb_read(32'h3000_003C, d, got);
    chk("unmap_ack", 32'(got), 1);
    chk("unmap_dat", d, 0);
    wb_read(32'h2000_0000, d, got);
    chk("nibble_noack", 32'(got), 0);

    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_IRQE; sel = 4'hF;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[3-i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("ack_pattern", 32'(pat), 32'h0000_000A);
    @(posedge clk); #1;

    wb_write(A_CTRL, 32'h0000_0101, 4'hF);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_sw", 32'({srst, sp1, sp2, pdone}), 0);
    chk("mid_rst_misc", 32'({alld, irq, ack}), 0);
    mon(12);
    tally(12, 0, nr, n1, n2, nd, fd, oh);
    chk("mid_rst_quiet", nr + n1 + n2 + nd, 0);
    wb_read(A_STAT, d, got);
    chk("mid_rst_stat", d, 0);
    wb_read(32'h3000_0040, d, got);
    chk("mid_rst_loc0", d, 0);
    wb_read(A_CTRL, d, got);
    chk("mid_rst_ctrl", d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
